sync_inst_fifo_mw: RTL and testbench
====================================

Name: sync_inst_fifo_mw

Overview:
Multi-width synchronous instruction FIFO: the successor to the single-entry instruction FIFO. Accepts up to ENQ_W instruction words per cycle from fetch and releases up to DEQ_W per cycle to decode. Decode sees a show-ahead window of the oldest DEQ_W entries, so it can consume an instruction together with its postfix immediate(s) in one cycle. Illegal requests are rejected atomically and flagged, never corrupting state.

Parameters:
WIDTH, 64, bits per entry
SIZE, 8, entry count; power of two, >= 4, >= ENQ_W and >= DEQ_W
ENQ_W, 2, max entries enqueued per cycle (>= 1)
DEQ_W, 2, max entries dequeued per cycle and peek window depth (>= 1)
ALMOST_FULL_THRESHOLD, SIZE-ENQ_W, almost_full when count >= this
ALMOST_EMPTY_THRESHOLD, 1, almost_empty when count <= this

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush_en  in  1  synchronous flush; overrides enq/deq
enq_cnt  in  $clog2(ENQ_W+1)  entries to enqueue this cycle (0..ENQ_W)
enq_data  in  ENQ_W*WIDTH  lane i at [i*WIDTH +: WIDTH]; lane 0 is oldest
deq_cnt  in  $clog2(DEQ_W+1)  entries to dequeue this cycle (0..DEQ_W)
peek_data  out  DEQ_W*WIDTH  lane j = entry head+j (mod SIZE), combinational
peek_valid  out  DEQ_W  bit j = (count > j)
count  out  $clog2(SIZE)+1  entries held
free  out  $clog2(SIZE)+1  SIZE - count
full  out  1  count == SIZE
empty  out  1  count == 0
almost_full  out  1  count >= ALMOST_FULL_THRESHOLD
almost_empty  out  1  count <= ALMOST_EMPTY_THRESHOLD
last_deq  out  WIDTH  registered copy of peek lane 0 at the last accepted nonzero dequeue
enq_err  out  1  one-cycle pulse: enqueue rejected
deq_err  out  1  one-cycle pulse: dequeue rejected

Behaviour:
- Reset (sync, highest priority): head=0, tail=0, count=0, last_deq=0, enq_err=0, deq_err=0. Storage array is not cleared. Reset mid-burst discards all entries.
- Flush (no reset): head=tail=count=0, enq_err=deq_err=0, last_deq held. Same-cycle enq/deq ignored.
- Acceptance is evaluated against the pre-edge count:
  - deq_ok = (deq_cnt <= count) and deq_cnt <= DEQ_W.
  - enq_ok = (enq_cnt <= free) and enq_cnt <= ENQ_W. Same-cycle dequeue does not free space for enqueue (conservative).
  - Rejection is all-or-nothing. A rejected side makes no state change and pulses its err flag next cycle. The other side proceeds independently.
- Accepted enqueue k: data[tail+i] <= lane i for i < k; tail <= tail+k (mod SIZE).
- Accepted dequeue d: head <= head+d (mod SIZE). If d > 0, last_deq <= peek lane 0.
- count_next = count + k_acc - d_acc, using $clog2(SIZE)+1-bit arithmetic. It never exceeds SIZE or goes below 0.
- Wrap-around: pointer sums are taken modulo SIZE. Multi-lane writes and peeks straddling index SIZE-1 -> 0 must be correct.
- Peek data for lanes with peek_valid=0 is don't-care. A write becomes visible in peek_data the cycle after enqueue (no same-cycle bypass).
- Latency: enqueue to peek_valid = 1 cycle. The flag outputs (full, empty, almost_*, free) are combinational from count.
- Simultaneous enq+deq on a full FIFO with enq_cnt > 0: enqueue is rejected (enq_err), dequeue is accepted.

Test Plan:
- Reset then idle -> count=0, empty=1, almost_empty=1, free=8, peek_valid=00, errs 0.
- Enqueue k=2 {A0,A1}, then k=2 {A2,A3}; next deq_cnt=2 -> peek_data {A0,A1} before the dequeue; after it, peek {A2,A3}, last_deq=A0, count=2.
- Fill to 8, then enq_cnt=1 with deq_cnt=1 same cycle -> enq_err pulses one cycle, count=7, full=0; peek lane 0 = entry 1.
- From count=1, deq_cnt=2 -> deq_err pulses, head and count unchanged; a simultaneous enq_cnt=2 is still accepted, count=3.
- Wrap: step head/tail to 7, enqueue {B0,B1} -> B0 at index 7, B1 at index 0; peek returns {B0,B1} in order and count tracks correctly.
- Flush with enq_cnt=2, deq_cnt=1 asserted -> count=0, empty=1, last_deq unchanged. Then a reset with count=5 -> count=0 and last_deq=0 next cycle.

Source files
------------

// File: rtl/sync_inst_fifo_mw.sv
// Multi-width synchronous instruction FIFO.
// Fetch pushes up to ENQ_W words per cycle. Decode sees a show-ahead window
// of the oldest DEQ_W entries and pops up to DEQ_W words per cycle.
// Requests that cannot be honoured are dropped whole and flagged one cycle later.
module sync_inst_fifo_mw #(
   parameter int WIDTH                  = 64,
   parameter int SIZE                   = 8,
   parameter int ENQ_W                  = 2,
   parameter int DEQ_W                  = 2,
   parameter int ALMOST_FULL_THRESHOLD  = SIZE - ENQ_W,
   parameter int ALMOST_EMPTY_THRESHOLD = 1,
   localparam int PTR_W  = $clog2(SIZE),
   localparam int CNT_W  = PTR_W + 1,
   localparam int ENQ_CW = $clog2(ENQ_W + 1),
   localparam int DEQ_CW = $clog2(DEQ_W + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush_en,
   input  logic [ENQ_CW-1:0]      enq_cnt,
   input  logic [ENQ_W*WIDTH-1:0] enq_data,
   input  logic [DEQ_CW-1:0]      deq_cnt,
   output logic [DEQ_W*WIDTH-1:0] peek_data,
   output logic [DEQ_W-1:0]       peek_valid,
   output logic [CNT_W-1:0]       count,
   output logic [CNT_W-1:0]       free,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [WIDTH-1:0]       last_deq,
   output logic                   enq_err,
   output logic                   deq_err
);

   localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);
   localparam logic [CNT_W-1:0] ENQ_MAX = CNT_W'(ENQ_W);
   localparam logic [CNT_W-1:0] DEQ_MAX = CNT_W'(DEQ_W);
   localparam logic [CNT_W-1:0] AF_TH = CNT_W'(ALMOST_FULL_THRESHOLD);
   localparam logic [CNT_W-1:0] AE_TH = CNT_W'(ALMOST_EMPTY_THRESHOLD);

   logic [WIDTH-1:0] mem [SIZE];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] enq_n;
   logic [CNT_W-1:0] deq_n;
   logic             enq_ok;
   logic             deq_ok;

   // Status flags are pure functions of the registered occupancy.
   assign free         = SIZE_C - count;
   assign full         = (count == SIZE_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_TH);
   assign almost_empty = (count <= AE_TH);

   // Acceptance is judged against the pre-edge occupancy. A same-cycle pop
   // does not make room for a push, which keeps the enqueue check independent
   // of the dequeue path.
   always_comb begin
      enq_n  = CNT_W'(enq_cnt);
      deq_n  = CNT_W'(deq_cnt);
      enq_ok = (enq_n <= ENQ_MAX) && (enq_n <= free);
      deq_ok = (deq_n <= DEQ_MAX) && (deq_n <= count);
   end

   // Show-ahead window: lane j is the entry at head+j. Pointer sums wrap
   // naturally because SIZE is a power of two.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
      peek_data  = '0;
      peek_valid = '0;
      for (int j = 0; j < DEQ_W; j++) begin
         peek_data[j*WIDTH +: WIDTH] = mem[head + PTR_W'(j)];
         peek_valid[j]               = (count > CNT_W'(j));
      end
   end

   // Storage write: accepted lanes land at tail, tail+1, ... (mod SIZE).
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset. The pointers and count define validity, and a reset port on the array would stop it mapping onto RAM.
      if (!reset && !flush_en && enq_ok) begin
         for (int i = 0; i < ENQ_W; i++) begin
            if (i < int'(enq_cnt)) begin
               mem[tail + PTR_W'(i)] <= enq_data[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Pointers, occupancy, the last-dequeued word and the error pulses. Reset wins over flush, and flush wins over traffic.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      if (reset) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         last_deq <= '0;
         enq_err  <= 1'b0;
         deq_err  <= 1'b0;
      end else if (flush_en) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         enq_err <= 1'b0;
         deq_err <= 1'b0;
      end else begin
         enq_err <= !enq_ok;
         deq_err <= !deq_ok;
         if (enq_ok) begin
            tail <= tail + PTR_W'(enq_cnt);
         end
         if (deq_ok) begin
            head <= head + PTR_W'(deq_cnt);
            if (deq_cnt != '0) begin
               last_deq <= peek_data[WIDTH-1:0];
            end
         end
         count <= count + (enq_ok ? enq_n : '0) - (deq_ok ? deq_n : '0);
      end
   end

endmodule

// File: tb/tb_sync_inst_fifo_mw.sv
// Directed testbench for sync_inst_fifo_mw (default parameters: 64-bit entries,
// 8 entries, 2-wide push and pop). Expected values are worked out by hand in each task.
module tb_sync_inst_fifo_mw;

   logic         clk;
   logic         reset;
   logic         flush_en;
   logic [1:0]   enq_cnt;
   logic [127:0] enq_data;
   logic [1:0]   deq_cnt;
   logic [127:0] peek_data;
   logic [1:0]   peek_valid;
   logic [3:0]   count;
   logic [3:0]   free;
   logic         full;
   logic         empty;
   logic         almost_full;
   logic         almost_empty;
   logic [63:0]  last_deq;
   logic         enq_err;
   logic         deq_err;

   int n_cmp = 0;
   int n_bad = 0;

   sync_inst_fifo_mw dut (
      .clk          (clk),
      .reset        (reset),
      .flush_en     (flush_en),
      .enq_cnt      (enq_cnt),
      .enq_data     (enq_data),
      .deq_cnt      (deq_cnt),
      .peek_data    (peek_data),
      .peek_valid   (peek_valid),
      .count        (count),
      .free         (free),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .last_deq     (last_deq),
      .enq_err      (enq_err),
      .deq_err      (deq_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] w(input logic [7:0] tag, input int idx);
      return {tag, 56'(idx)};
   endfunction

   // Advance one clock and settle 1 ns past the edge before sampling.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] e, input logic [63:0] l0, input logic [63:0] l1,
                        input logic [1:0] d);
      enq_cnt  = e;
      enq_data = {l1, l0};
      deq_cnt  = d;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush_en = 1'b0;
      drive(2'd0, '0, '0, 2'd0);
      cycle(); cycle();
      reset = 1'b0;
      n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
      n_cmp++; if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0)
         begin n_bad++; $display("FAIL reset_flags: empty=%b ae=%b full=%b want 1 1 0", empty, almost_empty, full); end
      n_cmp++; if (free !== 4'd8) begin n_bad++; $display("FAIL reset_free: got %0d want 8", free); end
      n_cmp++; if (peek_valid !== 2'b00) begin n_bad++; $display("FAIL reset_peek_valid: got %b want 00", peek_valid); end
      n_cmp++; if (enq_err !== 1'b0 || deq_err !== 1'b0)
         begin n_bad++; $display("FAIL reset_errs: enq_err=%b deq_err=%b want 0 0", enq_err, deq_err); end
      n_cmp++; if (last_deq !== 64'd0) begin n_bad++; $display("FAIL reset_last_deq: got %h want 0", last_deq); end
   endtask

   // head=tail=0 on entry; leaves head=tail=4, empty.
   task automatic test_basic();
      drive(2'd2, w(8'hA0, 0), w(8'hA0, 1), 2'd0); cycle();
      n_cmp++; if (count !== 4'd2 || peek_valid !== 2'b11 || almost_empty !== 1'b0)
         begin n_bad++; $display("FAIL basic_first: count=%0d pv=%b ae=%b want 2 11 0", count, peek_valid, almost_empty); end
      drive(2'd2, w(8'hA0, 2), w(8'hA0, 3), 2'd0); cycle();
      n_cmp++; if (count !== 4'd4) begin n_bad++; $display("FAIL basic_count4: got %0d want 4", count); end
      drive(2'd0, '0, '0, 2'd2);
      n_cmp++; if (peek_data !== {w(8'hA0, 1), w(8'hA0, 0)})
         begin n_bad++; $display("FAIL basic_peek_pre: got %h want A0,A1", peek_data); end
      cycle();
      n_cmp++; if (peek_data !== {w(8'hA0, 3), w(8'hA0, 2)})
         begin n_bad++; $display("FAIL basic_peek_post: got %h want A2,A3", peek_data); end
      n_cmp++; if (last_deq !== w(8'hA0, 0)) begin n_bad++; $display("FAIL basic_last_deq: got %h want %h", last_deq, w(8'hA0, 0)); end
      n_cmp++; if (count !== 4'd2) begin n_bad++; $display("FAIL basic_count2: got %0d want 2", count); end
      cycle();
      drive(2'd0, '0, '0, 2'd0);
      n_cmp++; if (count !== 4'd0 || empty !== 1'b1)
         begin n_bad++; $display("FAIL basic_drain: count=%0d empty=%b want 0 1", count, empty); end
   endtask

   // head=tail=4 on entry; leaves head=tail=4, empty, last_deq=C7.
   task automatic test_full();
      for (int k = 0; k < 4; k++) begin
         drive(2'd2, w(8'hC0, 2*k), w(8'hC0, 2*k+1), 2'd0); cycle();
         if (k == 1) begin
            n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL full_af_at4: got %b want 0", almost_full); end
         end
         if (k == 2) begin
            n_cmp++; if (almost_full !== 1'b1 || full !== 1'b0)
               begin n_bad++; $display("FAIL full_af_at6: af=%b full=%b want 1 0", almost_full, full); end
         end
      end
      n_cmp++; if (count !== 4'd8 || full !== 1'b1 || free !== 4'd0)
         begin n_bad++; $display("FAIL full_at8: count=%0d full=%b free=%0d want 8 1 0", count, full, free); end
      drive(2'd1, w(8'hC0, 8), '0, 2'd1); cycle();
      drive(2'd0, '0, '0, 2'd0);
      n_cmp++; if (enq_err !== 1'b1 || deq_err !== 1'b0)
         begin n_bad++; $display("FAIL full_enq_err: enq_err=%b deq_err=%b want 1 0", enq_err, deq_err); end
      n_cmp++; if (count !== 4'd7 || full !== 1'b0)
         begin n_bad++; $display("FAIL full_after: count=%0d full=%b want 7 0", count, full); end
      n_cmp++; if (peek_data[63:0] !== w(8'hC0, 1) || last_deq !== w(8'hC0, 0))
         begin n_bad++; $display("FAIL full_peek: lane0=%h last=%h want C1 C0", peek_data[63:0], last_deq); end
      cycle();
      n_cmp++; if (enq_err !== 1'b0) begin n_bad++; $display("FAIL full_err_pulse: got %b want 0", enq_err); end
      drive(2'd0, '0, '0, 2'd2); cycle(); cycle(); cycle();
      drive(2'd0, '0, '0, 2'd1); cycle();
      drive(2'd0, '0, '0, 2'd0);
      n_cmp++; if (count !== 4'd0 || last_deq !== w(8'hC0, 7))
         begin n_bad++; $display("FAIL full_drain: count=%0d last=%h want 0 C7", count, last_deq); end
   endtask

   // head=tail=4 on entry; leaves head=tail=7, empty.
   task automatic test_deq_err();
      drive(2'd1, w(8'hD0, 0), '0, 2'd0); cycle();
      n_cmp++; if (count !== 4'd1 || almost_empty !== 1'b1 || peek_valid !== 2'b01)
         begin n_bad++; $display("FAIL deqerr_setup: count=%0d ae=%b pv=%b want 1 1 01", count, almost_empty, peek_valid); end
      drive(2'd2, w(8'hD0, 1), w(8'hD0, 2), 2'd2); cycle();
      drive(2'd0, '0, '0, 2'd0);
      n_cmp++; if (deq_err !== 1'b1 || enq_err !== 1'b0)
         begin n_bad++; $display("FAIL deqerr_flag: deq_err=%b enq_err=%b want 1 0", deq_err, enq_err); end
      n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL deqerr_count: got %0d want 3", count); end
      n_cmp++; if (peek_data !== {w(8'hD0, 1), w(8'hD0, 0)} || last_deq !== w(8'hC0, 7))
         begin n_bad++; $display("FAIL deqerr_head: peek=%h last=%h want D0,D1 last C7", peek_data, last_deq); end
      cycle();
      n_cmp++; if (deq_err !== 1'b0) begin n_bad++; $display("FAIL deqerr_pulse: got %b want 0", deq_err); end
      drive(2'd0, '0, '0, 2'd2); cycle();
      drive(2'd0, '0, '0, 2'd1); cycle();
      drive(2'd0, '0, '0, 2'd0);
      n_cmp++; if (count !== 4'd0 || last_deq !== w(8'hD0, 2))
         begin n_bad++; $display("FAIL deqerr_drain: count=%0d last=%h want 0 D2", count, last_deq); end
   endtask

   // head=tail=7 on entry: the pair straddles index 7 -> 0.
   task automatic test_wrap();
      drive(2'd2, w(8'hB0, 0), w(8'hB0, 1), 2'd0); cycle();
      n_cmp++; if (peek_data !== {w(8'hB0, 1), w(8'hB0, 0)} || count !== 4'd2)
         begin n_bad++; $display("FAIL wrap_peek: peek=%h count=%0d want B0,B1 2", peek_data, count); end
      drive(2'd2, w(8'hB0, 2), w(8'hB0, 3), 2'd2); cycle();
      drive(2'd0, '0, '0, 2'd0);
      n_cmp++; if (peek_data !== {w(8'hB0, 3), w(8'hB0, 2)} || count !== 4'd2 || last_deq !== w(8'hB0, 0))
         begin n_bad++; $display("FAIL wrap_both: peek=%h count=%0d last=%h want B2,B3 2 B0", peek_data, count, last_deq); end
   endtask

   task automatic test_flush_reset();
      flush_en = 1'b1;
      drive(2'd2, w(8'hE0, 0), w(8'hE0, 1), 2'd1); cycle();
      flush_en = 1'b0;
      drive(2'd0, '0, '0, 2'd0);
      n_cmp++; if (count !== 4'd0 || empty !== 1'b1 || peek_valid !== 2'b00)
         begin n_bad++; $display("FAIL flush_state: count=%0d empty=%b pv=%b want 0 1 00", count, empty, peek_valid); end
      n_cmp++; if (last_deq !== w(8'hB0, 0)) begin n_bad++; $display("FAIL flush_last_deq: got %h want B0", last_deq); end
      drive(2'd2, w(8'hF0, 0), w(8'hF0, 1), 2'd0); cycle();
      drive(2'd2, w(8'hF0, 2), w(8'hF0, 3), 2'd0); cycle();
      drive(2'd1, w(8'hF0, 4), '0, 2'd0); cycle();
      drive(2'd0, '0, '0, 2'd0);
      n_cmp++; if (count !== 4'd5 || peek_data[63:0] !== w(8'hF0, 0))
         begin n_bad++; $display("FAIL flush_refill: count=%0d lane0=%h want 5 F0", count, peek_data[63:0]); end
      reset = 1'b1; cycle(); reset = 1'b0;
      n_cmp++; if (count !== 4'd0 || last_deq !== 64'd0 || empty !== 1'b1)
         begin n_bad++; $display("FAIL reset_mid: count=%0d last=%h empty=%b want 0 0 1", count, last_deq, empty); end
      drive(2'd3, w(8'hF0, 9), w(8'hF0, 9), 2'd0); cycle();
      drive(2'd0, '0, '0, 2'd0);
      n_cmp++; if (enq_err !== 1'b1 || count !== 4'd0)
         begin n_bad++; $display("FAIL enq_over_width: enq_err=%b count=%0d want 1 0", enq_err, count); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_deq_err();
      test_wrap();
      test_flush_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
